sweep_sequencer: RTL and testbench
==================================

SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

Interface
REQ-001 The block SHALL expose parameter POINTS_PER_DECADE, default 10, giving frequency points per DDS decade range.
REQ-002 The block SHALL expose parameter TIMEOUT_CYC, default 5000000, giving the capture watchdog limit in clock cycles.
REQ-003 Ports SHALL be:
 Fg_CLK  in  1  sole clock, all logic on rising edge;
 Fg_RESET  in  1  synchronous active-high reset;
 iStart  in  1  one-cycle sweep start request;
 iAbort  in  1  abort current sweep;
 iNumPoints  in  8  sweep length in points, 0 treated as 1;
 iSettleCyc  in  16  DDS settle wait in cycles after each load;
 iCaptureDone  in  1  one-cycle measurement-complete pulse;
 oFreqIdx  out  8  current point index;
 oDDSMode  out  3  DDS decade range, 0..3;
 oFreqLoad  out  1  one-cycle pulse, DDS latches oFreqIdx/oDDSMode;
 oCaptureReq  out  1  level, held until capture done/abort/timeout;
 oBusy  out  1  high in any state except IDLE;
 oSweepDone  out  1  one-cycle pulse on normal completion;
 oTimeout  out  1  sticky watchdog flag.

Function
REQ-004 FSM states SHALL be IDLE, LOAD, SETTLE, CAPTURE, NEXT, DONE.
REQ-005 In IDLE, iStart=1 SHALL latch iNumPoints (0->1), clear oFreqIdx, point sub-counter, oDDSMode and oTimeout, and enter LOAD next cycle.
REQ-006 iStart while oBusy=1 SHALL be ignored.
REQ-007 LOAD SHALL last exactly one cycle with oFreqLoad=1, then enter SETTLE.
REQ-008 SETTLE SHALL last max(iSettleCyc,1) cycles, iSettleCyc sampled on SETTLE entry, then enter CAPTURE.
REQ-009 CAPTURE SHALL drive oCaptureReq=1 from its first cycle; iCaptureDone=1 SHALL enter NEXT next cycle with oCaptureReq=0.
REQ-010 iCaptureDone outside CAPTURE SHALL be ignored.
REQ-011 NEXT (one cycle) SHALL enter DONE if oFreqIdx == latched count-1, else increment oFreqIdx and enter LOAD.
REQ-012 On each increment, the point sub-counter SHALL wrap at POINTS_PER_DECADE-1 and each wrap SHALL increment oDDSMode, saturating at 3.
REQ-013 DONE SHALL last one cycle with oSweepDone=1, then enter IDLE.
REQ-014 iAbort=1 in any non-IDLE state SHALL enter IDLE next cycle, deassert oCaptureReq, suppress oSweepDone, and leave oFreqIdx/oDDSMode holding last values.
REQ-015 Simultaneous iAbort and iCaptureDone SHALL resolve as abort.
REQ-016 Per-point latency from oFreqLoad to oCaptureReq SHALL be 1+max(iSettleCyc,1) cycles.

Reset
REQ-017 Fg_RESET=1 at a clock edge SHALL force IDLE, all outputs 0 and all counters 0, including mid-sweep.
REQ-018 The cycle after Fg_RESET deasserts SHALL accept iStart.

Configuration
REQ-019 With SWEEP_TIMEOUT_EN defined, CAPTURE lasting TIMEOUT_CYC cycles without iCaptureDone SHALL set oTimeout=1 and enter IDLE without oSweepDone.
REQ-020 Without SWEEP_TIMEOUT_EN, oTimeout SHALL be tied 0, no watchdog counter SHALL exist, and CAPTURE SHALL wait indefinitely.

Structure
REQ-021 State encodings, MODE_MAX=3 and TIMEOUT_CYC default SHALL live in shared package impedance_pkg.
REQ-022 A sub-module cycle_timer (loadable down-counter, 23-bit, expired flag) SHALL serve both SETTLE and the watchdog, never active simultaneously.

Verification
REQ-023 iNumPoints=3, iSettleCyc=4, capture done 2 cycles after each request -> 3 oFreqLoad pulses with idx 0,1,2, load-to-request gap 5 cycles, one oSweepDone.
REQ-024 iNumPoints=35, POINTS_PER_DECADE=10 -> oDDSMode 0 for idx 0-9, 1 for 10-19, 2 for 20-29, 3 for 30-34.
REQ-025 iNumPoints=0, iSettleCyc=0 -> exactly one point, SETTLE one cycle, oSweepDone after capture.
REQ-026 iAbort same cycle as iCaptureDone at idx 1 -> IDLE next cycle, no oSweepDone, oFreqIdx=1; then iStart restarts at idx 0.
REQ-027 SWEEP_TIMEOUT_EN, TIMEOUT_CYC=100, no iCaptureDone -> oCaptureReq falls after 100 cycles, oTimeout=1 until next iStart.
REQ-028 Fg_RESET pulsed during SETTLE at idx 2 -> all outputs 0 next cycle; iStart during busy ignored throughout.

Source files
------------

// File: rtl/impedance_pkg.sv
// Shared types and constants for the impedance sweep sequencer.
// State encodings, DDS decade limit and watchdog defaults live here.
package impedance_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_NEXT    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [2:0] MODE_MAX = 3'd3;
  localparam int TIMEOUT_CYC_DEF = 5000000;
  localparam int TMR_W = 23;

  // Timer preset giving max(cyc,1) cycles of SETTLE.
  function automatic logic [TMR_W-1:0] settle_preset(
    input logic [15:0] cyc
  );
    return (cyc == 16'd0) ? '0 : TMR_W'(cyc - 16'd1);
  endfunction

endpackage

// File: rtl/sweep_sequencer_timer.sv
// cycle_timer: loadable down-counter with expired flag.
// Shared between SETTLE wait and CAPTURE watchdog.
module cycle_timer
  import impedance_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  // Load takes priority; otherwise count down to zero and hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/sweep_sequencer.sv
// sweep_sequencer: steps a DDS through N frequency points.
// Optional capture watchdog enabled by defining SWEEP_TIMEOUT_EN.
module sweep_sequencer
  import impedance_pkg::*;
#(
  parameter int POINTS_PER_DECADE = 10,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        Fg_CLK,
  input  logic        Fg_RESET,
  input  logic        iStart,
  input  logic        iAbort,
  input  logic [7:0]  iNumPoints,
  input  logic [15:0] iSettleCyc,
  input  logic        iCaptureDone,
  output logic [7:0]  oFreqIdx,
  output logic [2:0]  oDDSMode,
  output logic        oFreqLoad,
  output logic        oCaptureReq,
  output logic        oBusy,
  output logic        oSweepDone,
  output logic        oTimeout
);

  localparam logic [7:0] PPD_LAST = 8'(POINTS_PER_DECADE - 1);
  localparam logic [TMR_W-1:0] TO_PRESET =
    TMR_W'(((TIMEOUT_CYC < 1) ? 1 : TIMEOUT_CYC) - 1);

  state_t           r_state;
  logic [7:0]       r_num;
  logic [7:0]       r_idx;
  logic [7:0]       r_sub;
  logic [2:0]       r_mode;
  logic             r_load;
  logic             r_req;
  logic             r_busy;
  logic             r_done;
  logic             r_tout;
  logic             w_expired;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;

  // Timer preset: settle length in LOAD, watchdog on CAPTURE entry.
  always_comb begin
    w_tmr_val  = (r_state == ST_LOAD) ?
                 settle_preset(iSettleCyc) : TO_PRESET;
    w_tmr_load = (r_state == ST_LOAD);
`ifdef SWEEP_TIMEOUT_EN
    if (r_state == ST_SETTLE && w_expired && !iAbort)
      w_tmr_load = 1'b1;
`endif
  end

  cycle_timer #(.W(TMR_W)) u_timer (
    .i_clk     (Fg_CLK),
    .i_rst     (Fg_RESET),
    .i_load    (w_tmr_load),
    .i_val     (w_tmr_val),
    .o_expired (w_expired)
  );

  // Sweep FSM with registered outputs; abort overrides every state.
  always_ff @(posedge Fg_CLK) begin
    if (Fg_RESET) begin
      r_state <= ST_IDLE;
      r_num   <= '0;
      r_idx   <= '0;
      r_sub   <= '0;
      r_mode  <= '0;
      r_load  <= 1'b0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tout  <= 1'b0;
    end else begin
      r_load <= 1'b0;
      r_done <= 1'b0;
      if (r_state != ST_IDLE && iAbort) begin
        r_state <= ST_IDLE;
        r_req   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (iStart) begin
              r_num   <= (iNumPoints == 8'd0) ? 8'd1 : iNumPoints;
              r_idx   <= '0;
              r_sub   <= '0;
              r_mode  <= '0;
              r_tout  <= 1'b0;
              r_load  <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            r_state <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (w_expired) begin
              r_req   <= 1'b1;
              r_state <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            if (iCaptureDone) begin
              r_req   <= 1'b0;
              r_state <= ST_NEXT;
            end
`ifdef SWEEP_TIMEOUT_EN
            else if (w_expired) begin
              r_req   <= 1'b0;
              r_tout  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
`endif
          end
          ST_NEXT: begin
            if (r_idx == r_num - 8'd1) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_idx   <= r_idx + 8'd1;
              r_load  <= 1'b1;
              r_state <= ST_LOAD;
              if (r_sub == PPD_LAST) begin
                r_sub <= '0;
                if (r_mode < MODE_MAX)
                  r_mode <= r_mode + 3'd1;
              end else begin
                r_sub <= r_sub + 8'd1;
              end
            end
          end
          ST_DONE: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign oFreqIdx    = r_idx;
  assign oDDSMode    = r_mode;
  assign oFreqLoad   = r_load;
  assign oCaptureReq = r_req;
  assign oBusy       = r_busy;
  assign oSweepDone  = r_done;
  assign oTimeout    = r_tout;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Testbench for sweep_sequencer: vector table, random sweeps
// against a point-level model, and hand-written corner sequences.
module tb_sweep_sequencer;

  localparam int PPD = 10;
  localparam int TO  = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        cdone = 1'b0;
  logic [7:0]  npts = '0;
  logic [15:0] settle = '0;
  logic [7:0]  idx;
  logic [2:0]  mode;
  logic        load, req, busy, sdone, tout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sweep_sequencer #(
    .POINTS_PER_DECADE (PPD),
    .TIMEOUT_CYC       (TO)
  ) dut (
    .Fg_CLK       (clk),
    .Fg_RESET     (rst),
    .iStart       (start),
    .iAbort       (abort),
    .iNumPoints   (npts),
    .iSettleCyc   (settle),
    .iCaptureDone (cdone),
    .oFreqIdx     (idx),
    .oDDSMode     (mode),
    .oFreqLoad    (load),
    .oCaptureReq  (req),
    .oBusy        (busy),
    .oSweepDone   (sdone),
    .oTimeout     (tout)
  );

  typedef struct {
    int n;
    int s;
    int d;
    bit spam;
    int exp_loads;
    int exp_gap;
    int exp_mode;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic outs_zero(input string tag);
    chk({tag, "_idx"}, 32'(idx), 0);
    chk({tag, "_mode"}, 32'(mode), 0);
    chk({tag, "_ctl"},
        32'({load, req, busy, sdone, tout}), 0);
  endtask

  // Full sweep: checks every load point and request latency.
  task automatic run_sweep(input int n, input int s,
                           input int d, input bit spam,
                           input int exp_loads,
                           input int exp_gap,
                           input int exp_mode);
    int loads = 0;
    int dones = 0;
    int cyc = 0;
    int since = -1;
    int reqk = 0;
    int last_mode = -1;
    bit prev_req = 1'b0;
    bit fin = 1'b0;
    npts = 8'(n);
    settle = 16'(s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 5000) begin
      cdone = 1'b0;
      start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      if (load) begin
        chk("pt_idx", 32'(idx), 32'(loads));
        chk("pt_mode", 32'(mode), 32'(mn(loads / PPD, 3)));
        last_mode = int'(mode);
        loads++;
        since = 0;
      end else if (since >= 0) begin
        since++;
      end
      if (req && !prev_req)
        chk("gap", 32'(since), 32'(exp_gap));
      if (req) begin
        reqk++;
        if (reqk == d) cdone = 1'b1;
      end else begin
        reqk = 0;
        if (spam) cdone = 1'($urandom_range(0, 1));
      end
      if (sdone) begin
        dones++;
        fin = 1'b1;
        start = 1'b0;
        cdone = 1'b0;
      end
      prev_req = req;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    cdone = 1'b0;
    if (!fin) chk("sweep_bound", 0, 1);
    chk("loads", 32'(loads), 32'(exp_loads));
    chk("last_mode", 32'(last_mode), 32'(exp_mode));
    chk("dones", 32'(dones), 1);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_sdone", 32'(sdone), 0);
  endtask

  // Advance, answering capture requests, until cond idx/req met.
  task automatic run_until(input int tgt_idx, input bit want_req,
                           input bit answer);
    int k = 0;
    bit hit = 1'b0;
    while (!hit && k < 2000) begin
      cdone = 1'b0;
      if (idx == 8'(tgt_idx) &&
          (want_req ? req : load)) begin
        hit = 1'b1;
      end else begin
        if (req && answer) cdone = 1'b1;
        @(negedge clk);
        k++;
      end
    end
    cdone = 1'b0;
    if (!hit) chk("wait_bound", 0, 1);
  endtask

  initial begin
    int n, s, d, l;
    int seen;
    vecs[0] = '{3, 4, 2, 1'b0, 3, 5, 0};
    vecs[1] = '{35, 1, 1, 1'b0, 35, 2, 3};
    vecs[2] = '{0, 0, 1, 1'b0, 1, 2, 0};
    vecs[3] = '{12, 2, 3, 1'b1, 12, 3, 1};
    vecs[4] = '{1, 7, 1, 1'b1, 1, 8, 0};
    vecs[5] = '{20, 0, 2, 1'b1, 20, 2, 1};

    repeat (2) @(negedge clk);
    outs_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_sweep(vecs[i].n, vecs[i].s, vecs[i].d, vecs[i].spam,
                vecs[i].exp_loads, vecs[i].exp_gap,
                vecs[i].exp_mode);

    for (int i = 0; i < 6; i++) begin
      n = int'($urandom_range(0, 45));
      s = int'($urandom_range(0, 6));
      d = int'($urandom_range(1, 4));
      l = (n == 0) ? 1 : n;
      run_sweep(n, s, d, 1'($urandom_range(0, 1)), l,
                1 + ((s == 0) ? 1 : s), mn((l - 1) / PPD, 3));
    end

    // Abort coinciding with capture done at idx 1.
    npts = 8'd5;
    settle = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_until(1, 1'b1, 1'b1);
    abort = 1'b1;
    cdone = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cdone = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_req", 32'(req), 0);
    chk("abort_idx", 32'(idx), 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (sdone || busy) seen++;
      @(negedge clk);
    end
    chk("abort_quiet", 32'(seen), 0);
    npts = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_load", 32'(load), 1);
    chk("restart_idx", 32'(idx), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort2_busy", 32'(busy), 0);

    // Reset in SETTLE at idx 2, then immediate restart.
    npts = 8'd5;
    settle = 16'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_until(2, 1'b0, 1'b1);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("settle_idx", 32'(idx), 2);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    outs_zero("midrst");
    rst = 1'b0;
    npts = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("postrst_load", 32'(load), 1);
    chk("postrst_idx", 32'(idx), 0);

    // Capture with no done: watchdog or indefinite wait.
    run_until(0, 1'b1, 1'b0);
    seen = 0;
`ifdef SWEEP_TIMEOUT_EN
    while (req && seen < 1000) begin
      seen++;
      @(negedge clk);
    end
    chk("to_len", 32'(seen), 32'(TO));
    chk("to_flag", 32'(tout), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_sdone", 32'(sdone), 0);
    repeat (3) @(negedge clk);
    chk("to_sticky", 32'(tout), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("to_clear", 32'(tout), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
`else
    while (req && seen < 3 * TO) begin
      seen++;
      @(negedge clk);
    end
    chk("wait_len", 32'(seen), 32'(3 * TO));
    chk("no_tout", 32'(tout), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("wait_abort", 32'({req, busy}), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
